// File: rtl/dc_port_arb_if.sv
// Bundle for the shared dcache port: LSQ and aux request/response channels plus
// the single downstream dcache channel.
interface dc_port_arb_if;
    logic        lsq_req;
    logic [3:0]  lsq_op;
    logic [31:0] lsq_addr;
    logic [3:0]  lsq_id;
    logic [31:0] lsq_wdata;
    logic        lsq_flush;
    logic        arb_lsq_ready;
    logic        arb_lsq_valid;
    logic        arb_lsq_error;
    logic [3:0]  arb_lsq_id;
    logic [31:0] arb_lsq_rdata;

    logic        aux_req;
    logic [3:0]  aux_op;
    logic [31:0] aux_addr;
    logic [3:0]  aux_id;
    logic [31:0] aux_wdata;
    logic        arb_aux_ready;
    logic        arb_aux_valid;
    logic        arb_aux_error;
    logic [3:0]  arb_aux_id;
    logic [31:0] arb_aux_rdata;

    logic        arb_dc_req;
    logic [3:0]  arb_dc_op;
    logic [31:0] arb_dc_addr;
    logic [4:0]  arb_dc_id;
    logic [31:0] arb_dc_wdata;
    logic        arb_dc_flush;
    logic        dc_arb_ready;
    logic        dc_arb_valid;
    logic        dc_arb_error;
    logic [4:0]  dc_arb_id;
    logic [31:0] dc_arb_rdata;

    modport slave (
        input  lsq_req, lsq_op, lsq_addr, lsq_id, lsq_wdata, lsq_flush,
        output arb_lsq_ready, arb_lsq_valid, arb_lsq_error, arb_lsq_id, arb_lsq_rdata,
        input  aux_req, aux_op, aux_addr, aux_id, aux_wdata,
        output arb_aux_ready, arb_aux_valid, arb_aux_error, arb_aux_id, arb_aux_rdata,
        output arb_dc_req, arb_dc_op, arb_dc_addr, arb_dc_id, arb_dc_wdata, arb_dc_flush,
        input  dc_arb_ready, dc_arb_valid, dc_arb_error, dc_arb_id, dc_arb_rdata
    );

    modport master (
        output lsq_req, lsq_op, lsq_addr, lsq_id, lsq_wdata, lsq_flush,
        input  arb_lsq_ready, arb_lsq_valid, arb_lsq_error, arb_lsq_id, arb_lsq_rdata,
        output aux_req, aux_op, aux_addr, aux_id, aux_wdata,
        input  arb_aux_ready, arb_aux_valid, arb_aux_error, arb_aux_id, arb_aux_rdata,
        input  arb_dc_req, arb_dc_op, arb_dc_addr, arb_dc_id, arb_dc_wdata, arb_dc_flush,
        output dc_arb_ready, dc_arb_valid, dc_arb_error, dc_arb_id, dc_arb_rdata
    );
endinterface

// File: rtl/dc_port_arb.sv
// Shares one dcache port between the LSQ (priority) and an aux requester, with
// aux starvation override, flush-squashed LSQ load tracking and an aux load cap.
module dc_port_arb #(
    parameter int STARVE_LIMIT = 4,
    parameter int AUX_MAX_OUT  = 4
) (
    input logic         clk,
    input logic         rst,
    dc_port_arb_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {W_NONE, W_LSQ, W_AUX} win_e;

    logic [15:0]   lsq_pend, lsq_dead, rsp_hit, beat_set;
    logic [3:0]    aux_cnt;
    logic [SW-1:0] starve_cnt;
    win_e          win;
    logic          lsq_load, aux_load, lsq_ok, aux_ok, lsq_beat, aux_beat;
    logic          rsp_lsq, rsp_aux, lsq_deliver, aux_deliver;

    assign lsq_load = ~bus.lsq_op[0];
    assign aux_load = ~bus.aux_op[0];
    assign lsq_ok   = bus.lsq_req & ~(lsq_load & lsq_pend[bus.lsq_id]);
    assign aux_ok   = bus.aux_req & ~(aux_load & (aux_cnt == 4'(AUX_MAX_OUT)));

    // Nothing is issued while the pipeline flushes or the block is in reset.
    always_comb begin
        win = W_NONE;
        if (!rst && !bus.lsq_flush) begin
            if (aux_ok && (starve_cnt == SW'(STARVE_LIMIT) || !lsq_ok)) win = W_AUX;
            else if (lsq_ok)                                           win = W_LSQ;
        end
    end

    assign lsq_beat          = (win == W_LSQ) & bus.dc_arb_ready;
    assign aux_beat          = (win == W_AUX) & bus.dc_arb_ready;
    assign bus.arb_lsq_ready = lsq_beat;
    assign bus.arb_aux_ready = aux_beat;
    assign bus.arb_dc_req    = (win != W_NONE);
    assign bus.arb_dc_flush  = bus.lsq_flush;

    always_comb begin
        bus.arb_dc_op    = '0;
        bus.arb_dc_addr  = '0;
        bus.arb_dc_id    = '0;
        bus.arb_dc_wdata = '0;
        case (win)
            W_LSQ: begin
                bus.arb_dc_op    = bus.lsq_op;
                bus.arb_dc_addr  = bus.lsq_addr;
                bus.arb_dc_id    = {1'b0, bus.lsq_id};
                bus.arb_dc_wdata = bus.lsq_wdata;
            end
            W_AUX: begin
                bus.arb_dc_op    = bus.aux_op;
                bus.arb_dc_addr  = bus.aux_addr;
                bus.arb_dc_id    = {1'b1, bus.aux_id};
                bus.arb_dc_wdata = bus.aux_wdata;
            end
            default: ;
        endcase
    end

    assign rsp_lsq = bus.dc_arb_valid & ~bus.dc_arb_id[4];
    assign rsp_aux = bus.dc_arb_valid &  bus.dc_arb_id[4];
    // A flush in the same cycle squashes the response as if it were already dead.
    assign lsq_deliver = rsp_lsq & lsq_pend[bus.dc_arb_id[3:0]]
                       & ~lsq_dead[bus.dc_arb_id[3:0]] & ~bus.lsq_flush;
    assign aux_deliver = rsp_aux & (aux_cnt != 4'd0);
    assign rsp_hit     = rsp_lsq ? (16'd1 << bus.dc_arb_id[3:0]) : 16'd0;
    assign beat_set    = (lsq_beat & lsq_load) ? (16'd1 << bus.lsq_id) : 16'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            lsq_pend          <= '0;
            lsq_dead          <= '0;
            aux_cnt           <= '0;
            starve_cnt        <= '0;
            bus.arb_lsq_valid <= 1'b0;
            bus.arb_lsq_error <= 1'b0;
            bus.arb_lsq_id    <= '0;
            bus.arb_lsq_rdata <= '0;
            bus.arb_aux_valid <= 1'b0;
            bus.arb_aux_error <= 1'b0;
            bus.arb_aux_id    <= '0;
            bus.arb_aux_rdata <= '0;
        end else begin
            lsq_pend <= (lsq_pend & ~rsp_hit) | beat_set;
            lsq_dead <= (lsq_dead | (bus.lsq_flush ? lsq_pend : 16'd0)) & ~rsp_hit & ~beat_set;
            aux_cnt  <= aux_cnt + {3'd0, aux_beat & aux_load} - {3'd0, aux_deliver};
            if (!bus.lsq_flush) begin
                if (!bus.aux_req || aux_beat)              starve_cnt <= '0;
                else if (starve_cnt != SW'(STARVE_LIMIT))  starve_cnt <= starve_cnt + SW'(1);
            end
            bus.arb_lsq_valid <= lsq_deliver;
            bus.arb_aux_valid <= aux_deliver;
            if (lsq_deliver) begin
                bus.arb_lsq_error <= bus.dc_arb_error;
                bus.arb_lsq_id    <= bus.dc_arb_id[3:0];
                bus.arb_lsq_rdata <= bus.dc_arb_rdata;
            end
            if (aux_deliver) begin
                bus.arb_aux_error <= bus.dc_arb_error;
                bus.arb_aux_id    <= bus.dc_arb_id[3:0];
                bus.arb_aux_rdata <= bus.dc_arb_rdata;
            end
        end
    end
endmodule

// File: tb/tb_dc_port_arb.sv
// Directed scenarios then random traffic, every cycle checked against a
// behavioural model of the arbiter plus a queue-based dcache responder.
module tb_dc_port_arb;
  localparam int SL = 4;
  localparam int AM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dc_port_arb_if bus();
  dc_port_arb #(.STARVE_LIMIT(SL), .AUX_MAX_OUT(AM)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vec = 0, miss = 0;
  bit mp[16], md[16];
  int acnt = 0, starve = 0;
  bit e_lv = 0, e_av = 0, e_lerr = 0, e_aerr = 0;
  logic [3:0] e_lid = '0, e_aid = '0;
  logic [31:0] e_lrd = '0, e_ard = '0;
  logic [4:0] dq[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.lsq_req = 0; bus.lsq_op = 0; bus.lsq_addr = 0; bus.lsq_id = 0; bus.lsq_wdata = 0;
    bus.lsq_flush = 0; bus.aux_req = 0; bus.aux_op = 0; bus.aux_addr = 0; bus.aux_id = 0;
    bus.aux_wdata = 0; bus.dc_arb_ready = 1; bus.dc_arb_valid = 0; bus.dc_arb_error = 0;
    bus.dc_arb_id = 0; bus.dc_arb_rdata = 0;
  endtask

  // Drive the response for outstanding entry k of the dcache model.
  task automatic resp(int k, logic [31:0] data);
    bus.dc_arb_valid = 1;
    bus.dc_arb_id    = dq[k];
    bus.dc_arb_rdata = data;
    bus.dc_arb_error = 1'($urandom_range(7, 0) == 0);
    dq.delete(k);
  endtask

  task automatic resp_id(logic [4:0] id, logic [31:0] data);
    for (int k = 0; k < dq.size(); k++)
      if (dq[k] == id) begin resp(k, data); return; end
    chk("resp_id_outstanding", 32'(id), 32'h1F);
  endtask

  // One clock: check outputs against the model just before the edge, advance the model.
  task automatic step();
    bit lld, ald, lok, aok, lbeat, abeat, fl;
    int win;
    logic [3:0] ri;
    @(negedge clk);
    fl  = bus.lsq_flush;
    lld = !bus.lsq_op[0];
    ald = !bus.aux_op[0];
    lok = bus.lsq_req && !(lld && mp[bus.lsq_id]);
    aok = bus.aux_req && !(ald && acnt >= AM);
    win = 0;
    if (!rst && !fl) begin
      if (aok && (starve >= SL || !lok)) win = 2;
      else if (lok)                      win = 1;
    end
    lbeat = (win == 1) && bus.dc_arb_ready;
    abeat = (win == 2) && bus.dc_arb_ready;
    chk("dc_req", 32'(bus.arb_dc_req), 32'(win != 0));
    chk("lsq_ready", 32'(bus.arb_lsq_ready), 32'(lbeat));
    chk("aux_ready", 32'(bus.arb_aux_ready), 32'(abeat));
    chk("dc_flush", 32'(bus.arb_dc_flush), 32'(fl));
    if (win == 1) begin
      chk("dc_id_lsq", 32'(bus.arb_dc_id), 32'({1'b0, bus.lsq_id}));
      chk("dc_addr_lsq", bus.arb_dc_addr, bus.lsq_addr);
      chk("dc_op_lsq", 32'(bus.arb_dc_op), 32'(bus.lsq_op));
    end else if (win == 2) begin
      chk("dc_id_aux", 32'(bus.arb_dc_id), 32'({1'b1, bus.aux_id}));
      chk("dc_wdata_aux", bus.arb_dc_wdata, bus.aux_wdata);
    end
    chk("lsq_valid", 32'(bus.arb_lsq_valid), 32'(e_lv));
    chk("aux_valid", 32'(bus.arb_aux_valid), 32'(e_av));
    if (e_lv) begin
      chk("lsq_rid", 32'(bus.arb_lsq_id), 32'(e_lid));
      chk("lsq_rdata", bus.arb_lsq_rdata, e_lrd);
      chk("lsq_err", 32'(bus.arb_lsq_error), 32'(e_lerr));
    end
    if (e_av) begin
      chk("aux_rid", 32'(bus.arb_aux_id), 32'(e_aid));
      chk("aux_rdata", bus.arb_aux_rdata, e_ard);
      chk("aux_err", 32'(bus.arb_aux_error), 32'(e_aerr));
    end
    e_lv = 0; e_av = 0;
    if (rst) begin
      foreach (mp[i]) begin mp[i] = 0; md[i] = 0; end
      acnt = 0; starve = 0; dq.delete();
    end else begin
      if (bus.dc_arb_valid) begin
        ri = bus.dc_arb_id[3:0];
        if (!bus.dc_arb_id[4]) begin
          if (mp[ri] && !md[ri] && !fl) begin
            e_lv = 1; e_lid = ri; e_lrd = bus.dc_arb_rdata; e_lerr = bus.dc_arb_error;
          end
          mp[ri] = 0; md[ri] = 0;
        end else if (acnt > 0) begin
          e_av = 1; e_aid = ri; e_ard = bus.dc_arb_rdata; e_aerr = bus.dc_arb_error;
          acnt--;
        end
      end
      if (fl) foreach (md[i]) md[i] = md[i] | mp[i];
      if (lbeat && lld) begin
        mp[bus.lsq_id] = 1; md[bus.lsq_id] = 0; dq.push_back({1'b0, bus.lsq_id});
      end
      if (abeat && ald) begin acnt++; dq.push_back({1'b1, bus.aux_id}); end
      if (!fl) starve = (!bus.aux_req || abeat) ? 0 : ((starve < SL) ? starve + 1 : SL);
    end
    @(posedge clk); #1;
    bus.dc_arb_valid = 0;
  endtask

  task automatic drain();
    bus.lsq_req = 0; bus.aux_req = 0; bus.lsq_flush = 0;
    for (int n = 0; n < 64 && dq.size() > 0; n++) begin
      resp(0, $urandom);
      step();
    end
    step();
  endtask

  initial begin
    idle();
    // reset state
    step(); step();
    chk("rst_lsq_valid", 32'(bus.arb_lsq_valid), 32'd0);
    chk("rst_dc_req", 32'(bus.arb_dc_req), 32'd0);
    rst = 0;
    step();

    // 1: both load every cycle -> LSQ x4 then aux, repeating
    for (int c = 0; c < 10; c++) begin
      bus.lsq_req = 1; bus.lsq_op = 4'b0000; bus.lsq_id = 4'(c); bus.lsq_addr = 32'(c * 4);
      bus.aux_req = 1; bus.aux_op = 4'b0010; bus.aux_id = 4'(c); bus.aux_addr = 32'h1000 + 32'(c);
      #1;
      chk("s1_winner_msb", 32'(bus.arb_dc_id[4]), 32'(c % 5 == 4));
      step();
    end
    drain();

    // 2: single LSQ load id 3 and its response
    bus.lsq_req = 1; bus.lsq_op = 4'b0000; bus.lsq_id = 4'd3; bus.lsq_addr = 32'h40;
    step();
    bus.lsq_req = 0;
    resp_id(5'h03, 32'hDEADBEEF);
    bus.dc_arb_error = 0;
    step();
    chk("s2_valid", 32'(bus.arb_lsq_valid), 32'd1);
    chk("s2_id", 32'(bus.arb_lsq_id), 32'd3);
    chk("s2_rdata", bus.arb_lsq_rdata, 32'hDEADBEEF);
    chk("s2_aux_valid", 32'(bus.arb_aux_valid), 32'd0);

    // 3: loads 1 and 2 outstanding, then flush
    bus.lsq_req = 1; bus.lsq_id = 4'd1; step();
    bus.lsq_id = 4'd2; step();
    bus.lsq_req = 0; bus.lsq_flush = 1;
    #1;
    chk("s3_flush_req", 32'(bus.arb_dc_req), 32'd0);
    chk("s3_flush_pass", 32'(bus.arb_dc_flush), 32'd1);
    step();
    bus.lsq_flush = 0;

    // 4: reuse dead id 1 -> blocked until its stale response is dropped
    bus.lsq_req = 1; bus.lsq_id = 4'd1;
    #1; chk("s4_blocked", 32'(bus.arb_lsq_ready), 32'd0);
    step(); step();
    resp_id(5'h01, 32'h11111111);
    step();
    chk("s4_dropped", 32'(bus.arb_lsq_valid), 32'd0);
    chk("s4_granted", 32'(bus.arb_lsq_ready), 32'd1);
    step();
    bus.lsq_req = 0;
    resp_id(5'h02, 32'h22222222);
    step();
    chk("s4_dropped2", 32'(bus.arb_lsq_valid), 32'd0);
    drain();

    // 5: aux load cap
    for (int c = 0; c < 4; c++) begin
      bus.aux_req = 1; bus.aux_op = 4'b0000; bus.aux_id = 4'(c); step();
    end
    bus.aux_id = 4'd4;
    #1; chk("s5_capped", 32'(bus.arb_aux_ready), 32'd0);
    step();
    bus.aux_op = 4'b0001;
    #1; chk("s5_store_ok", 32'(bus.arb_aux_ready), 32'd1);
    step();
    bus.aux_op = 4'b0000;
    resp_id(5'h10, 32'hA0A0A0A0);
    step();
    chk("s5_uncapped", 32'(bus.arb_aux_ready), 32'd1);
    step();
    drain();

    // 6: dcache stalls, then reset mid-stream
    bus.lsq_req = 1; bus.lsq_op = 4'b0000; bus.lsq_id = 4'd7;
    bus.aux_req = 1; bus.aux_op = 4'b0000; bus.aux_id = 4'd9;
    bus.dc_arb_ready = 0;
    step(); step(); step();
    bus.dc_arb_ready = 1;
    step(); step();
    rst = 1;
    step();
    chk("s6_rst_req", 32'(bus.arb_dc_req), 32'd0);
    chk("s6_rst_ready", 32'(bus.arb_lsq_ready | bus.arb_aux_ready), 32'd0);
    chk("s6_rst_valid", 32'(bus.arb_lsq_valid | bus.arb_aux_valid), 32'd0);
    chk("s6_rst_rdata", bus.arb_lsq_rdata | bus.arb_aux_rdata, 32'd0);
    rst = 0;
    step();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      bus.lsq_req   = 1'($urandom_range(3, 0) != 0);
      bus.lsq_op    = {3'($urandom), 1'($urandom_range(2, 0) == 0)};
      bus.lsq_id    = 4'($urandom);
      bus.lsq_addr  = $urandom;
      bus.lsq_wdata = $urandom;
      bus.aux_req   = 1'($urandom_range(1, 0));
      bus.aux_op    = {3'($urandom), 1'($urandom_range(3, 0) == 0)};
      bus.aux_id    = 4'($urandom);
      bus.aux_addr  = $urandom;
      bus.aux_wdata = $urandom;
      bus.dc_arb_ready = 1'($urandom_range(4, 0) != 0);
      bus.lsq_flush = 1'($urandom_range(24, 0) == 0);
      if (dq.size() > 0 && $urandom_range(1, 0) == 1)
        resp(int'($urandom_range(dq.size() - 1, 0)), $urandom);
      rst = 1'($urandom_range(299, 0) == 0);
      step();
      rst = 0;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
